// File: rtl/gbe_rx_eof_counter.sv
// End-of-frame event counter feeding the rxeofctr software register.
// Optional bad-frame counter when RXEOFCTR_BADFRAME_EN is defined.
module gbe_rx_eof_counter #(
   parameter int CNT_W    = 32,
   parameter bit SATURATE = 1'b0
) (
   input  logic        user_clk,
   input  logic        user_rst_n,
   input  logic        gbe_rx_valid,
   input  logic        gbe_rx_end_of_frame,
   input  logic        gbe_rx_bad_frame,
   input  logic [31:0] ctrl_in,
   output logic [31:0] cnt_out,
   output logic [31:0] bad_cnt_out,
   output logic        ovf_out
);

   typedef enum logic [1:0] {
      DISABLED  = 2'd0,
      COUNTING  = 2'd1,
      SATURATED = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_PEN = CNT_MAX - 1'b1;

   state_t           state;
   logic             clr_d;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;

   logic ev, clr_pulse, en, freeze, at_max, run, hit_max;

   assign ev        = gbe_rx_valid & gbe_rx_end_of_frame;
   assign en        = ctrl_in[1];
   assign freeze    = ctrl_in[2];
   assign clr_pulse = ctrl_in[0] & ~clr_d;
   assign at_max    = (cnt_q == CNT_MAX);
   // Enable acts on the current level so the first EOF after enabling counts.
   assign run       = en & ~(SATURATE & at_max);
   assign hit_max   = ev & run & (cnt_q == CNT_PEN);

   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         state   <= DISABLED;
         clr_d   <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_out <= 32'h0;
         ovf_out <= 1'b0;
      end else begin
         clr_d <= ctrl_in[0];
         if (clr_pulse) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            state <= en ? COUNTING : DISABLED;
         end else begin
            if (ev && run) begin
               if (at_max) begin
                  cnt_q <= '0;
                  ovf_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (SATURATE && hit_max)
                     ovf_q <= 1'b1;
               end
            end
            if (!en)
               state <= DISABLED;
            else if (SATURATE && (at_max || hit_max))
               state <= SATURATED;
            else
               state <= COUNTING;
         end
         if (!freeze) begin
            cnt_out <= 32'(cnt_q);
            ovf_out <= ovf_q;
         end
      end
   end

`ifdef RXEOFCTR_BADFRAME_EN
   logic [CNT_W-1:0] bad_q;
   logic             bad_at_max;

   assign bad_at_max = (bad_q == CNT_MAX);

   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         bad_q       <= '0;
         bad_cnt_out <= 32'h0;
      end else begin
         if (clr_pulse)
            bad_q <= '0;
         else if (ev && run && gbe_rx_bad_frame) begin
            if (!bad_at_max)
               bad_q <= bad_q + 1'b1;
            else if (!SATURATE)
               bad_q <= '0;
         end
         if (!freeze)
            bad_cnt_out <= 32'(bad_q);
      end
   end

   wire unused_ok = &{1'b0, state, ctrl_in[31:3]};
`else
   assign bad_cnt_out = 32'h0;

   // State is kept for observation only; the bad-frame input has no consumer here.
   wire unused_ok = &{1'b0, state, gbe_rx_bad_frame, ctrl_in[31:3]};
`endif

endmodule

// File: tb/tb_gbe_rx_eof_counter.sv
// Self-checking bench for gbe_rx_eof_counter: three instances (32-bit wrap,
// 4-bit wrap, 4-bit saturate) share stimulus; expectations flow through a queue.
module tb_gbe_rx_eof_counter;

   logic        user_clk = 1'b0;
   logic        user_rst_n;
   logic        gbe_rx_valid, gbe_rx_end_of_frame, gbe_rx_bad_frame;
   logic [31:0] ctrl_in;

   logic [31:0] cnt_a, bad_a, cnt_w, bad_w, cnt_s, bad_s;
   logic        ovf_a, ovf_w, ovf_s;

`ifdef RXEOFCTR_BADFRAME_EN
   localparam bit BAD_ON = 1'b1;
`else
   localparam bit BAD_ON = 1'b0;
`endif

   always #5 user_clk = ~user_clk;

   gbe_rx_eof_counter #(.CNT_W(32), .SATURATE(1'b0)) dut_a (
      .user_clk(user_clk), .user_rst_n(user_rst_n), .gbe_rx_valid(gbe_rx_valid),
      .gbe_rx_end_of_frame(gbe_rx_end_of_frame), .gbe_rx_bad_frame(gbe_rx_bad_frame),
      .ctrl_in(ctrl_in), .cnt_out(cnt_a), .bad_cnt_out(bad_a), .ovf_out(ovf_a));

   gbe_rx_eof_counter #(.CNT_W(4), .SATURATE(1'b0)) dut_w (
      .user_clk(user_clk), .user_rst_n(user_rst_n), .gbe_rx_valid(gbe_rx_valid),
      .gbe_rx_end_of_frame(gbe_rx_end_of_frame), .gbe_rx_bad_frame(gbe_rx_bad_frame),
      .ctrl_in(ctrl_in), .cnt_out(cnt_w), .bad_cnt_out(bad_w), .ovf_out(ovf_w));

   gbe_rx_eof_counter #(.CNT_W(4), .SATURATE(1'b1)) dut_s (
      .user_clk(user_clk), .user_rst_n(user_rst_n), .gbe_rx_valid(gbe_rx_valid),
      .gbe_rx_end_of_frame(gbe_rx_end_of_frame), .gbe_rx_bad_frame(gbe_rx_bad_frame),
      .ctrl_in(ctrl_in), .cnt_out(cnt_s), .bad_cnt_out(bad_s), .ovf_out(ovf_s));

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push3(input logic [31:0] c, input logic [31:0] b, input logic o);
      exp_q.push_back(c);
      exp_q.push_back(b);
      exp_q.push_back({31'b0, o});
   endtask

   task automatic sb_pop(output logic [31:0] v);
      if (exp_q.size() == 0) v = 'x;
      else v = exp_q.pop_front();
   endtask

   task automatic cmp3(input string tag, input logic [31:0] c, input logic [31:0] b, input logic o);
      logic [31:0] e;
      sb_pop(e); check({tag, ".cnt"}, c, e);
      sb_pop(e); check({tag, ".bad"}, b, e);
      sb_pop(e); check({tag, ".ovf"}, {31'b0, o}, e);
   endtask

   task automatic cmp_all(input string tag);
      cmp3({tag, ".a"}, cnt_a, bad_a, ovf_a);
      cmp3({tag, ".w"}, cnt_w, bad_w, ovf_w);
      cmp3({tag, ".s"}, cnt_s, bad_s, ovf_s);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge user_clk);
   endtask

   // One qualified EOF followed by one idle cycle, so cnt_out has settled on return.
   task automatic ev_pulse(input logic b);
      gbe_rx_valid = 1'b1; gbe_rx_end_of_frame = 1'b1; gbe_rx_bad_frame = b;
      idle(1);
      gbe_rx_valid = 1'b0; gbe_rx_end_of_frame = 1'b0; gbe_rx_bad_frame = 1'b0;
      idle(1);
   endtask

   task automatic set_ctrl(input logic [31:0] v);
      ctrl_in = v;
      idle(1);
   endtask

   task automatic do_reset();
      user_rst_n = 1'b0;
      idle(2);
      user_rst_n = 1'b1;
   endtask

   initial begin
      gbe_rx_valid = 1'b0; gbe_rx_end_of_frame = 1'b0; gbe_rx_bad_frame = 1'b0;
      ctrl_in = 32'h0;
      user_rst_n = 1'b0;
      idle(1);
      do_reset();
      push3(0, 0, 0); push3(0, 0, 0); push3(0, 0, 0);
      cmp_all("reset");

      // EOF without valid must be ignored.
      ctrl_in = 32'h2;
      gbe_rx_end_of_frame = 1'b1;
      idle(10);
      gbe_rx_end_of_frame = 1'b0;
      idle(1);
      push3(0, 0, 0); push3(0, 0, 0); push3(0, 0, 0);
      cmp_all("eof_no_valid");

      // Five events; cnt_out lags the counter by one cycle.
      for (int i = 0; i < 4; i++) ev_pulse(1'b0);
      gbe_rx_valid = 1'b1; gbe_rx_end_of_frame = 1'b1;
      idle(1);
      gbe_rx_valid = 1'b0; gbe_rx_end_of_frame = 1'b0;
      push3(4, 0, 0);
      cmp3("five_lag.a", cnt_a, bad_a, ovf_a);
      idle(1);
      push3(5, 0, 0); push3(5, 0, 0); push3(5, 0, 0);
      cmp_all("five");

      // Wrap versus saturate on 4-bit instances.
      do_reset();
      for (int i = 0; i < 17; i++) ev_pulse(1'b0);
      push3(17, 0, 0); push3(1, 0, 1); push3(15, 0, 1);
      cmp_all("seventeen");

      for (int i = 0; i < 7; i++) ev_pulse(1'b0);
      push3(24, 0, 0); push3(8, 0, 1); push3(15, 0, 1);
      cmp_all("plus_seven");

      // Clear rising together with an event: clear wins, ovf drops.
      ctrl_in = 32'h3;
      gbe_rx_valid = 1'b1; gbe_rx_end_of_frame = 1'b1;
      idle(1);
      gbe_rx_valid = 1'b0; gbe_rx_end_of_frame = 1'b0;
      idle(1);
      push3(0, 0, 0); push3(0, 0, 0); push3(0, 0, 0);
      cmp_all("clr_vs_ev");

      // Clear held high only clears once.
      for (int i = 0; i < 3; i++) ev_pulse(1'b0);
      idle(14);
      push3(3, 0, 0); push3(3, 0, 0); push3(3, 0, 0);
      cmp_all("clr_level");
      set_ctrl(32'h2);

      // Freeze holds outputs while counting continues.
      ev_pulse(1'b0);
      set_ctrl(32'h6);
      for (int i = 0; i < 6; i++) ev_pulse(1'b0);
      push3(4, 0, 0); push3(4, 0, 0); push3(4, 0, 0);
      cmp_all("frozen");
      set_ctrl(32'h2);
      push3(10, 0, 0); push3(10, 0, 0); push3(10, 0, 0);
      cmp_all("thawed");

      // Disabled: events ignored.
      set_ctrl(32'h0);
      ev_pulse(1'b0);
      ev_pulse(1'b0);
      set_ctrl(32'h2);
      push3(10, 0, 0);
      cmp3("disabled.a", cnt_a, bad_a, ovf_a);

      // Clear while frozen: output stays until release.
      set_ctrl(32'h6);
      set_ctrl(32'h7);
      set_ctrl(32'h6);
      push3(10, 0, 0);
      cmp3("clr_frozen.a", cnt_a, bad_a, ovf_a);
      set_ctrl(32'h2);
      push3(0, 0, 0);
      cmp3("clr_thaw.a", cnt_a, bad_a, ovf_a);

      // Bad-frame counting, then reset mid-sequence.
      do_reset();
      for (int i = 0; i < 8; i++) ev_pulse((i == 1) || (i == 4) || (i == 6));
      push3(8, BAD_ON ? 3 : 0, 0); push3(8, BAD_ON ? 3 : 0, 0); push3(8, BAD_ON ? 3 : 0, 0);
      cmp_all("bad_frames");

      ev_pulse(1'b1);
      gbe_rx_valid = 1'b1; gbe_rx_end_of_frame = 1'b1;
      user_rst_n = 1'b0;
      idle(1);
      push3(0, 0, 0); push3(0, 0, 0); push3(0, 0, 0);
      cmp_all("mid_reset");
      gbe_rx_valid = 1'b0; gbe_rx_end_of_frame = 1'b0;
      user_rst_n = 1'b1;
      idle(1);
      ev_pulse(1'b0);
      push3(1, 0, 0);
      cmp3("after_reset.a", cnt_a, bad_a, ovf_a);

      check("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
